// File: rtl/plab2_mem_responder_pkg.sv
// Shared message encodings for the plab2 memory responder.
// Message field widths, request types and FSM state encodings.
package plab2_mem_responder_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } mem_type_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/plab2_mem_responder_word_array.sv
// Word storage: synchronous write, combinational read.
// Owner tag bits exist only under PLAB2_MEM_DOMAIN_CHECK_EN.
module plab2_mem_WordArray
  import plab2_mem_responder_pkg::*;
#(
  parameter int p_nwords = 1024,
  localparam int AW = idx_w(p_nwords)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wtag,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata,
  output logic              rtag
);

  logic [DATA_W-1:0] mem_q [p_nwords];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

`ifdef PLAB2_MEM_DOMAIN_CHECK_EN
  logic [p_nwords-1:0] tag_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) tag_q <= '0;
    else if (we) tag_q[waddr] <= wtag;
  end

  assign rtag = tag_q[raddr];
`else
  logic unused_tag;

  assign unused_tag = ^{reset, wtag};
  assign rtag = 1'b0;
`endif

endmodule

// File: rtl/plab2_mem_responder.sv
// Single-outstanding val/rdy memory responder, fixed latency.
// PLAB2_MEM_DOMAIN_CHECK_EN adds per-word owner tags checked on reads.
module plab2_mem_responder
  import plab2_mem_responder_pkg::*;
#(
  parameter int          p_mem_nwords = 1024,
  parameter logic [31:0] p_base_addr  = 32'h0000_0000,
  parameter int          p_latency    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              domain,
  input  logic              memreq_val,
  output logic              memreq_rdy,
  input  logic              memreq_type,
  input  logic [ADDR_W-1:0] memreq_addr,
  input  logic [DATA_W-1:0] memreq_data,
  output logic              memresp_val,
  input  logic              memresp_rdy,
  output logic              memresp_type,
  output logic [DATA_W-1:0] memresp_data,
  output logic              memresp_err
);

  localparam int AW = idx_w(p_mem_nwords);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              val_q, val_d;
  logic              type_q, type_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              err_q, err_d;

  logic [ADDR_W-1:0] offset;
  logic [ADDR_W-1:0] word_idx;
  logic              range_err;
  logic              dom_err;
  logic              req_err;
  logic              fire;
  logic              we;
  logic [DATA_W-1:0] rd_data;
  logic              rd_tag;
  logic              unused_sig;

  // Below-base addresses are rejected explicitly so the
  // subtraction can never wrap back into range.
  assign offset    = memreq_addr - p_base_addr;
  assign word_idx  = {2'b00, offset[ADDR_W-1:2]};
  assign range_err = (memreq_addr[1:0] != 2'b00)
                   | (memreq_addr < p_base_addr)
                   | (word_idx >= 32'(p_mem_nwords));

`ifdef PLAB2_MEM_DOMAIN_CHECK_EN
  assign dom_err = (memreq_type == READ) & (rd_tag != domain);
`else
  assign dom_err = 1'b0;
`endif

  assign req_err    = range_err | dom_err;
  assign fire       = (state_q == IDLE) & memreq_val;
  assign we         = fire & (memreq_type == WRITE) & ~range_err;
  assign unused_sig = ^{offset[1:0], domain, rd_tag};

  plab2_mem_WordArray #(
    .p_nwords (p_mem_nwords)
  ) u_array (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .waddr (word_idx[AW-1:0]),
    .wdata (memreq_data),
    .wtag  (domain),
    .raddr (word_idx[AW-1:0]),
    .rdata (rd_data),
    .rtag  (rd_tag)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    val_d   = val_q;
    type_d  = type_q;
    data_d  = data_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (fire) begin
          type_d = memreq_type;
          err_d  = req_err;
          data_d = '0;
          if ((memreq_type == READ) && !req_err)
            data_d = rd_data;
          if (p_latency == 1) begin
            state_d = RESP;
            val_d   = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(p_latency - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          val_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (memresp_rdy) begin
          state_d = IDLE;
          val_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        val_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      val_q   <= 1'b0;
      type_q  <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      val_q   <= val_d;
      type_q  <= type_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign memreq_rdy   = (state_q == IDLE);
  assign memresp_val  = val_q;
  assign memresp_type = type_q;
  assign memresp_data = data_q;
  assign memresp_err  = err_q;

endmodule

// File: tb/tb_plab2_mem_responder.sv
// Scoreboard bench for plab2_mem_responder at latency 1 and 4.
module tb_plab2_mem_responder;

  localparam int          LAT  [2] = '{1, 4};
  localparam logic [31:0] BASE [2] = '{32'h0000_0000, 32'h0000_0100};
  localparam int          NW   [2] = '{1024, 64};

  typedef struct packed {
    logic        typ;
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst       [2];
  logic        dom       [2];
  logic        req_val   [2];
  logic        req_rdy   [2];
  logic        req_type  [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_data  [2];
  logic        resp_val  [2];
  logic        resp_rdy  [2];
  logic        resp_type [2];
  logic [31:0] resp_data [2];
  logic        resp_err  [2];

  exp_t        sbq [$];
  logic [31:0] mem_m [longint];
  bit          tag_m [longint];
  int          nvec  = 0;
  int          nfail = 0;

  always #5 clk = ~clk;

  plab2_mem_responder #(
    .p_mem_nwords (1024),
    .p_base_addr  (32'h0000_0000),
    .p_latency    (1)
  ) dut0 (
    .clk          (clk),
    .reset        (rst[0]),
    .domain       (dom[0]),
    .memreq_val   (req_val[0]),
    .memreq_rdy   (req_rdy[0]),
    .memreq_type  (req_type[0]),
    .memreq_addr  (req_addr[0]),
    .memreq_data  (req_data[0]),
    .memresp_val  (resp_val[0]),
    .memresp_rdy  (resp_rdy[0]),
    .memresp_type (resp_type[0]),
    .memresp_data (resp_data[0]),
    .memresp_err  (resp_err[0])
  );

  plab2_mem_responder #(
    .p_mem_nwords (64),
    .p_base_addr  (32'h0000_0100),
    .p_latency    (4)
  ) dut1 (
    .clk          (clk),
    .reset        (rst[1]),
    .domain       (dom[1]),
    .memreq_val   (req_val[1]),
    .memreq_rdy   (req_rdy[1]),
    .memreq_type  (req_type[1]),
    .memreq_addr  (req_addr[1]),
    .memreq_data  (req_data[1]),
    .memresp_val  (resp_val[1]),
    .memresp_rdy  (resp_rdy[1]),
    .memresp_type (resp_type[1]),
    .memresp_data (resp_data[1]),
    .memresp_err  (resp_err[1])
  );

  // Drive a request, update the reference model, push the expectation.
  task automatic fire(input int d, input logic typ, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic dm);
    exp_t        e;
    longint      key;
    logic [31:0] off;
    bit          tg;
    int          n;
    n = 0;
    @(negedge clk);
    while (req_rdy[d] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    nvec++;
    if (req_rdy[d] !== 1'b1) begin
      nfail++;
      $display("FAIL req_rdy_idle d=%0d got %b want 1", d, req_rdy[d]);
    end
    off   = addr - BASE[d];
    e.typ = typ;
    e.data = 32'h0;
    e.err = (addr[1:0] != 2'b00) || (addr < BASE[d]) ||
            ((off >> 2) >= 32'(NW[d]));
    key = longint'(d) * 65536 + longint'(off >> 2);
    if (!e.err) begin
      if (typ) begin
        mem_m[key] = wdata;
        tag_m[key] = dm;
      end else begin
        tg = tag_m.exists(key) ? tag_m[key] : 1'b0;
`ifdef PLAB2_MEM_DOMAIN_CHECK_EN
        if (tg != dm) e.err = 1'b1;
        else e.data = mem_m[key];
`else
        e.data = mem_m[key];
        if (tg) e.data = mem_m[key];
`endif
      end
    end
    dom[d]      = dm;
    req_type[d] = typ;
    req_addr[d] = addr;
    req_data[d] = wdata;
    req_val[d]  = 1'b1;
    @(posedge clk);
    sbq.push_back(e);
  endtask

  // Wait for the response, check latency, hold it for `stall` cycles.
  task automatic collect(input int d, input int stall);
    exp_t e;
    int   lat;
    @(negedge clk);
    req_val[d]  = 1'b0;
    req_addr[d] = $urandom;
    lat = 1;
    while (resp_val[d] !== 1'b1 && lat < 40) begin
      nvec++;
      if (req_rdy[d] !== 1'b0) begin
        nfail++;
        $display("FAIL busy_rdy d=%0d cyc=%0d got %b want 0", d, lat, req_rdy[d]);
      end
      @(negedge clk);
      lat++;
    end
    nvec++;
    if (resp_val[d] !== 1'b1 || lat != LAT[d]) begin
      nfail++;
      $display("FAIL latency d=%0d got val=%b lat=%0d want val=1 lat=%0d",
               d, resp_val[d], lat, LAT[d]);
    end
    if (sbq.size() == 0) begin
      nvec++;
      nfail++;
      $display("FAIL scoreboard_empty d=%0d got 0 entries want 1", d);
      return;
    end
    e = sbq.pop_front();
    for (int s = 0; s <= stall; s++) begin
      nvec++;
      if ({resp_type[d], resp_data[d], resp_err[d], resp_val[d], req_rdy[d]} !==
          {e.typ, e.data, e.err, 1'b1, 1'b0}) begin
        nfail++;
        $display("FAIL resp d=%0d hold=%0d got t=%b d=%h e=%b v=%b r=%b want t=%b d=%h e=%b v=1 r=0",
                 d, s, resp_type[d], resp_data[d], resp_err[d], resp_val[d],
                 req_rdy[d], e.typ, e.data, e.err);
      end
      if (s < stall) begin
        resp_rdy[d] = 1'b0;
        @(negedge clk);
      end
    end
    resp_rdy[d] = 1'b1;
    @(negedge clk);
    nvec++;
    if (resp_val[d] !== 1'b0 || req_rdy[d] !== 1'b1) begin
      nfail++;
      $display("FAIL drain d=%0d got val=%b rdy=%b want val=0 rdy=1",
               d, resp_val[d], req_rdy[d]);
    end
  endtask

  task automatic xact(input int d, input logic typ, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic dm, input int stall);
    fire(d, typ, addr, wdata, dm);
    collect(d, stall);
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; dom[d] = 1'b0; req_val[d] = 1'b0; req_type[d] = 1'b0;
      req_addr[d] = '0; req_data[d] = '0; resp_rdy[d] = 1'b1;
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      nvec++;
      if ({resp_val[d], resp_type[d], resp_data[d], resp_err[d], req_rdy[d]} !==
          {1'b0, 1'b0, 32'h0, 1'b0, 1'b1}) begin
        nfail++;
        $display("FAIL reset_state d=%0d got v=%b t=%b d=%h e=%b r=%b want 0 0 0 0 1",
                 d, resp_val[d], resp_type[d], resp_data[d], resp_err[d], req_rdy[d]);
      end
    end
    @(negedge clk);
    @(negedge clk);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
  endtask

  task automatic test_lat1_rw();
    xact(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 0);
    xact(0, 1'b0, 32'h0000_0010, 32'h0, 1'b0, 0);
    xact(0, 1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 0);
    xact(0, 1'b1, 32'h0000_0FFC, 32'h0BAD_F00D, 1'b0, 0);
    xact(0, 1'b0, 32'h0000_0000, 32'h0, 1'b0, 0);
    xact(0, 1'b0, 32'h0000_0FFC, 32'h0, 1'b0, 0);
  endtask

  task automatic test_lat4();
    xact(1, 1'b1, 32'h0000_0140, 32'h1357_9BDF, 1'b0, 0);
    xact(1, 1'b0, 32'h0000_0140, 32'h0, 1'b0, 0);
    xact(1, 1'b1, 32'h0000_01FC, 32'h2468_ACE0, 1'b0, 0);
    xact(1, 1'b0, 32'h0000_01FC, 32'h0, 1'b0, 0);
  endtask

  task automatic test_backpressure();
    xact(1, 1'b0, 32'h0000_0140, 32'h0, 1'b0, 3);
    xact(0, 1'b0, 32'h0000_0010, 32'h0, 1'b0, 3);
    xact(0, 1'b1, 32'h0000_0044, 32'h7777_1111, 1'b0, 2);
  endtask

  task automatic test_errors();
    xact(0, 1'b0, 32'h0000_0013, 32'h0, 1'b0, 0);
    xact(0, 1'b0, 32'h0000_1000, 32'h0, 1'b0, 0);
    xact(0, 1'b1, 32'h0000_1010, 32'h5555_5555, 1'b0, 0);
    xact(0, 1'b1, 32'h0000_0012, 32'h6666_6666, 1'b0, 0);
    xact(0, 1'b0, 32'h0000_0010, 32'h0, 1'b0, 0);
    xact(1, 1'b0, 32'h0000_00FC, 32'h0, 1'b0, 0);
    xact(1, 1'b1, 32'h0000_0040, 32'h9999_9999, 1'b0, 0);
    xact(1, 1'b0, 32'h0000_0200, 32'h0, 1'b0, 0);
    xact(1, 1'b0, 32'h0000_0140, 32'h0, 1'b0, 0);
  endtask

  task automatic test_reset_mid();
    exp_t dropped;
    fire(1, 1'b1, 32'h0000_0120, 32'h1234_5678, 1'b0);
    @(negedge clk);
    req_val[1] = 1'b0;
    @(negedge clk);
    rst[1] = 1'b1;
    #1;
    nvec++;
    if (resp_val[1] !== 1'b0 || req_rdy[1] !== 1'b1) begin
      nfail++;
      $display("FAIL reset_mid d=1 got val=%b rdy=%b want val=0 rdy=1",
               resp_val[1], req_rdy[1]);
    end
    dropped = sbq.pop_back();
`ifdef PLAB2_MEM_DOMAIN_CHECK_EN
    foreach (tag_m[k]) if ((k >> 16) == 1) tag_m[k] = 1'b0;
`endif
    @(negedge clk);
    rst[1] = 1'b0;
    xact(1, 1'b0, 32'h0000_0120, 32'h0, 1'b0, 0);
    xact(1, 1'b0, 32'h0000_0120, 32'h0, 1'b1, 0);
  endtask

  task automatic test_domain();
    xact(0, 1'b1, 32'h0000_0080, 32'hA5A5_A5A5, 1'b1, 0);
    xact(0, 1'b0, 32'h0000_0080, 32'h0, 1'b0, 0);
    xact(0, 1'b0, 32'h0000_0080, 32'h0, 1'b1, 0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] a [6];
    for (int i = 0; i < 6; i++) begin
      a[i] = {20'h0, 2'b01, 8'(i * 7 + $urandom_range(0, 6)), 2'b00};
      fire(0, 1'b1, a[i], $urandom, 1'b0);
      collect(0, 0);
    end
    for (int i = 0; i < 6; i++) begin
      fire(0, 1'b0, a[i], 32'h0, 1'b0);
      collect(0, i % 2);
    end
  endtask

  initial begin
    test_reset();
    test_lat1_rw();
    test_lat4();
    test_backpressure();
    test_errors();
    test_reset_mid();
    test_domain();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
